at86_iq_lvds_tx: RTL and testbench



---
 rtl/at86_iq_lvds_tx.sv | 143 ++++++++++++++
 tb/tb_at86_iq_lvds_tx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/at86_iq_lvds_tx.sv
// AT86RF215 TX I/Q serializer: accepts 32-bit {I,Q} words and shifts out 32-bit frames MSB-first.
// Optional: define AT86_IQ_TX_HOLD_LAST_EN to retransmit the last frame on underrun.
module at86_iq_lvds_tx (
    input  logic        clk,
    input  logic        reset,
    input  logic        tx_enable,
    input  logic [31:0] s_iq_data,
    input  logic        s_iq_valid,
    output logic        s_iq_ready,
    output logic        tx_data,
    output logic        tx_sync,
    output logic        tx_busy,
    output logic [15:0] underrun_cnt
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] hold_q;
    logic        hold_valid;
    logic [31:0] shift_q;
    logic [4:0]  bit_cnt;
    logic        sync_q;
    logic [15:0] underrun_q;
    logic        accept;
    logic        load_new;
    logic        load_last;
    logic        count_underrun;

    // Only the top 13 bits of each sample are transmitted.
    logic unused_low_bits;
    assign unused_low_bits = &{1'b0, s_iq_data[18:16], s_iq_data[2:0]};

    function automatic logic [31:0] build_frame(input logic [31:0] w);
        return {2'b10, w[31:19], 1'b0, 2'b01, w[15:3], 1'b0};
    endfunction

    assign accept       = s_iq_valid && !hold_valid;
    assign s_iq_ready   = !hold_valid;
    assign tx_data      = shift_q[31];
    assign tx_sync      = sync_q;
    assign tx_busy      = (state_q == SHIFT);
    assign underrun_cnt = underrun_q;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d        = state_q;
        load_new       = 1'b0;
        load_last      = 1'b0;
        count_underrun = 1'b0;
        case (state_q)
            IDLE: begin
                if (tx_enable && hold_valid) begin
                    state_d  = SHIFT;
                    load_new = 1'b1;
                end
            end
            SHIFT: begin
                if (bit_cnt == 5'd31) begin
                    if (tx_enable && hold_valid) begin
                        load_new = 1'b1;
                    end else if (tx_enable) begin
                        count_underrun = 1'b1;
`ifdef AT86_IQ_TX_HOLD_LAST_EN
                        load_last = 1'b1;
`else
                        state_d = IDLE;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef AT86_IQ_TX_HOLD_LAST_EN
    logic [31:0] last_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= '0;
        end else if (load_new) begin
            last_q <= hold_q;
        end
    end
`else
    logic [31:0] last_q;
    assign last_q = '0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            hold_valid <= 1'b0;
            bit_cnt    <= '0;
            sync_q     <= 1'b0;
            underrun_q <= '0;
        end else begin
            state_q <= state_d;
            sync_q  <= load_new || load_last;
            if (load_new) begin
                hold_valid <= 1'b0;
            end else if (accept) begin
                hold_valid <= 1'b1;
            end
            if (load_new || load_last) begin
                bit_cnt <= '0;
            end else if (state_q == SHIFT) begin
                bit_cnt <= bit_cnt + 5'd1;
            end
            if (count_underrun && underrun_q != 16'hFFFF) begin
                underrun_q <= underrun_q + 16'd1;
            end
        end
    end

    // NOTE: the data registers are reset too; an aborted frame must leave tx_data low at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q  <= '0;
            shift_q <= '0;
        end else begin
            if (accept) begin
                hold_q <= build_frame(s_iq_data);
            end
            // After 32 shifts the register is all zeros, which keeps tx_data low in IDLE.
            if (load_new) begin
                shift_q <= hold_q;
            end else if (load_last) begin
                shift_q <= last_q;
            end else if (state_q == SHIFT) begin
                shift_q <= {shift_q[30:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_at86_iq_lvds_tx.sv
// Directed self-checking bench for at86_iq_lvds_tx; honours AT86_IQ_TX_HOLD_LAST_EN when defined.
module tb_at86_iq_lvds_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        tx_enable;
    logic [31:0] s_iq_data;
    logic        s_iq_valid;
    logic        s_iq_ready;
    logic        tx_data;
    logic        tx_sync;
    logic        tx_busy;
    logic [15:0] underrun_cnt;

    int compared   = 0;
    int mismatched = 0;

    at86_iq_lvds_tx dut (
        .clk          (clk),
        .reset        (reset),
        .tx_enable    (tx_enable),
        .s_iq_data    (s_iq_data),
        .s_iq_valid   (s_iq_valid),
        .s_iq_ready   (s_iq_ready),
        .tx_data      (tx_data),
        .tx_sync      (tx_sync),
        .tx_busy      (tx_busy),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the handshake edge.
    task automatic send(input logic [31:0] w);
        int n = 0;
        s_iq_data  = w;
        s_iq_valid = 1'b1;
        while (!s_iq_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("send_ready_wait", 32'(n < 200), 32'd1);
        @(negedge clk);
        s_iq_valid = 1'b0;
    endtask

    // Collects 32 bits sampled on negedges; optionally drops tx_enable at bit index drop_at.
    task automatic capture(output logic [31:0] f, output logic [31:0] syncs,
                           output int busy_low, input int drop_at);
        f        = '0;
        syncs    = '0;
        busy_low = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            f     = {f[30:0], tx_data};
            syncs = {syncs[30:0], tx_sync};
            if (!tx_busy) busy_low++;
            if (i == drop_at) tx_enable = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] frame;
        logic [31:0] syncs;
        int          busy_low;
        int          activity;
        logic [31:0] words  [4];
        logic [31:0] frames [4];

        words[0]  = 32'hFFFF_0000; frames[0] = 32'hBFFE_4000;
        words[1]  = 32'h8000_7FF8; frames[1] = 32'hA000_5FFE;
        words[2]  = 32'h0007_0007; frames[2] = 32'h8000_4000;
        words[3]  = 32'h1234_ABCD; frames[3] = 32'h848C_6AF2;

        reset      = 1'b1;
        tx_enable  = 1'b0;
        s_iq_valid = 1'b0;
        s_iq_data  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state.
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_sync", tx_sync, 0);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_ready", s_iq_ready, 1);
        check("rst_underrun", underrun_cnt, 0);

        // Enabled with nothing held: stays idle, no underrun counted.
        tx_enable = 1'b1;
        repeat (6) @(negedge clk);
        check("idle_no_word_busy", tx_busy, 0);
        check("idle_no_word_cnt", underrun_cnt, 0);

        // Single word.
        send(32'h1234_ABCD);
        check("single_busy_pre_load", tx_busy, 0);
`ifdef AT86_IQ_TX_HOLD_LAST_EN
        capture(frame, syncs, busy_low, -1);
        check("single_frame", frame, 32'h848C_6AF2);
        check("single_sync", syncs, 32'h8000_0000);
        for (int r = 0; r < 3; r++) begin
            capture(frame, syncs, busy_low, (r == 2) ? 5 : -1);
            check("repeat_frame", frame, 32'h848C_6AF2);
            check("repeat_sync", syncs, 32'h8000_0000);
            check("repeat_busy", busy_low, 0);
        end
        @(negedge clk);
        check("repeat_end_busy", tx_busy, 0);
        check("repeat_end_data", tx_data, 0);
        check("repeat_underrun", underrun_cnt, 3);
        tx_enable = 1'b1;
`else
        capture(frame, syncs, busy_low, -1);
        check("single_frame", frame, 32'h848C_6AF2);
        check("single_sync", syncs, 32'h8000_0000);
        check("single_busy", busy_low, 0);
        @(negedge clk);
        check("single_end_busy", tx_busy, 0);
        check("single_end_data", tx_data, 0);
        check("single_underrun", underrun_cnt, 1);
        repeat (4) @(negedge clk);
        check("single_idle_data", tx_data, 0);
`endif

        // Back-to-back: four words fed as soon as ready.
        send(words[0]);
        fork
            begin
                send(words[1]);
                send(words[2]);
                send(words[3]);
            end
            begin
                for (int k = 0; k < 4; k++) begin
`ifdef AT86_IQ_TX_HOLD_LAST_EN
                    capture(frame, syncs, busy_low, (k == 3) ? 5 : -1);
`else
                    capture(frame, syncs, busy_low, -1);
`endif
                    check("b2b_frame", frame, frames[k]);
                    check("b2b_sync", syncs, 32'h8000_0000);
                    check("b2b_busy", busy_low, 0);
                end
            end
        join
        @(negedge clk);
        check("b2b_end_busy", tx_busy, 0);
`ifdef AT86_IQ_TX_HOLD_LAST_EN
        check("b2b_underrun", underrun_cnt, 3);
        tx_enable = 1'b1;
`else
        check("b2b_underrun", underrun_cnt, 2);
`endif

        // Disable at bit 10 while a second word is held.
        send(words[0]);
        fork
            send(words[1]);
            capture(frame, syncs, busy_low, 10);
        join
        check("dis_frame", frame, frames[0]);
        check("dis_sync", syncs, 32'h8000_0000);
        activity = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx_busy || tx_data) activity++;
        end
        check("dis_no_activity", activity, 0);
        check("dis_word_held", s_iq_ready, 0);
`ifdef AT86_IQ_TX_HOLD_LAST_EN
        check("dis_underrun", underrun_cnt, 3);
`else
        check("dis_underrun", underrun_cnt, 2);
`endif

        // Re-enable: held word goes out; reset around bit 20 with a further word held.
        tx_enable = 1'b1;
        @(negedge clk);
        check("rearm_first_bit", tx_data, 1);
        check("rearm_sync", tx_sync, 1);
        send(words[2]);
        repeat (17) @(negedge clk);
        check("mid_busy", tx_busy, 1);
        check("mid_word_held", s_iq_ready, 0);
        #2 reset = 1'b1;
        #1;
        check("arst_tx_data", tx_data, 0);
        check("arst_tx_busy", tx_busy, 0);
        check("arst_tx_sync", tx_sync, 0);
        check("arst_ready", s_iq_ready, 1);
        check("arst_underrun", underrun_cnt, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_busy", tx_busy, 0);

        // Saturation: preload the counter near its ceiling, then force three underruns.
        force dut.underrun_q = 16'hFFFD;
        #1 release dut.underrun_q;
        @(negedge clk);
        check("sat_preload", underrun_cnt, 16'hFFFD);
`ifdef AT86_IQ_TX_HOLD_LAST_EN
        send(words[3]);
        capture(frame, syncs, busy_low, -1);
        capture(frame, syncs, busy_low, -1);
        check("sat_after_1", underrun_cnt, 16'hFFFE);
        capture(frame, syncs, busy_low, -1);
        check("sat_after_2", underrun_cnt, 16'hFFFF);
        capture(frame, syncs, busy_low, 5);
        check("sat_frame", frame, 32'h848C_6AF2);
        @(negedge clk);
        check("sat_after_3", underrun_cnt, 16'hFFFF);
        check("sat_end_busy", tx_busy, 0);
`else
        for (int u = 0; u < 3; u++) begin
            send(words[u]);
            capture(frame, syncs, busy_low, -1);
            check("sat_frame", frame, frames[u]);
            @(negedge clk);
            case (u)
                0:       check("sat_after_1", underrun_cnt, 16'hFFFE);
                1:       check("sat_after_2", underrun_cnt, 16'hFFFF);
                default: check("sat_after_3", underrun_cnt, 16'hFFFF);
            endcase
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
